// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/ready                 operation handshake for requester N (N=0,1)
//   reqN_srca/srcb/op                operands and opcode of requester N
//   rspN_valid/ready                 result handshake for requester N
//   rspN_result                      registered ALU result for requester N
//   alu_srca/alu_srcb/alu_op         operands/opcode driven to the shared ALU
//   alu_result                       combinational result from the shared ALU
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_WIDTH-1:0]    rsp0_result,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp1_result,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  // ptr_q holds the index of the last granted requester; reset to 1 so
  // requester 0 wins the first tie.
  logic                  ptr_q, ptr_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic [DATA_WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic                  elig0, elig1;
  logic                  grant0, grant1;

  always_comb begin
    // A requester may issue only if its result slot is free or being drained
    // this cycle, which gives one op per cycle per requester back-to-back.
    elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
    elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready);

    // rst_n gates the grants so nothing is accepted (and later lost) while
    // the block is held in reset.
    grant0 = rst_n && elig0 && (!elig1 || ptr_q);
    grant1 = rst_n && elig1 && (!elig0 || !ptr_q);

    alu_srca = '0;
    alu_srcb = '0;
    alu_op   = '0;
    if (grant0) begin
      alu_srca = req0_srca;
      alu_srcb = req0_srcb;
      alu_op   = req0_op;
    end else if (grant1) begin
      alu_srca = req1_srca;
      alu_srcb = req1_srcb;
      alu_op   = req1_op;
    end

    ptr_d = ptr_q;
    if (grant0) begin
      ptr_d = 1'b0;
    end else if (grant1) begin
      ptr_d = 1'b1;
    end

    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    if (grant0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_result;
    end else if (rsp0_ready) begin
      rsp0_valid_d  = 1'b0;
    end

    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    if (grant1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_result;
    end else if (rsp1_ready) begin
      rsp1_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= 1'b1;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;

endmodule
